// File: rtl/pulse_period_meter.sv
// pulse_period_meter
//   Measures a slow pulse train (typically the divided clock of the chiaxung
//   divider) in units of clki cycles. Each rising edge of sig_in after the
//   first one produces a one-cycle meas_valid strobe. The strobe carries the
//   period and, when enabled, the high time of the period that just ended.
//
//   Optional feature: define PULSE_METER_DUTY_EN to build the high-time
//   counters. Without it, high_time is tied to zero and everything else is
//   unchanged.
//
// Parameters
//   CNT_W       width of the period/high-time counters and outputs
//   SYNC_STAGES synchronizer depth on sig_in (minimum 2)
//
// Ports
//   clki       in   system clock, all logic on the rising edge
//   rsti_n     in   asynchronous active-low reset
//   en         in   measurement enable; low returns the meter to IDLE
//   sig_in     in   pulse input, asynchronous to clki
//   period     out  clki cycles between the last two sig_in rising edges
//   high_time  out  clki cycles sig_in was high in the last measured period
//   meas_valid out  one-cycle strobe: period/high_time updated this cycle
//   locked     out  at least one full period measured since arming
//   overflow   out  sticky: the period counter saturated (cleared by en=0)
//   state_dbg  out  current FSM state (IDLE=0, ARM=1, MEASURE=2)
//
// Handshake: meas_valid is a strobe with no back-pressure. period and
// high_time are stable from the strobe cycle until the next strobe.
module pulse_period_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clki,
    input  logic             rsti_n,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             overflow,
    output logic [1:0]       state_dbg
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_MEAS = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   s_d;
    logic                   rise;
    logic [1:0]             state;
    logic [CNT_W-1:0]       cnt;

    // Synchronizer chain plus one extra flop for edge detection.
    always_ff @(posedge clki or negedge rsti_n) begin
        if (!rsti_n) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            s_d    <= s;
        end
    end

    assign s         = sync_q[SYNC_STAGES-1];
    assign rise      = s & ~s_d;
    assign state_dbg = state;

    // Period FSM. The counter value held when a rise arrives is the number
    // of cycles since the previous rise. A rise in the same cycle as
    // saturation is still a valid measurement of CNT_MAX, because the rise
    // branch is checked first.
    always_ff @(posedge clki or negedge rsti_n) begin
        if (!rsti_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            period     <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (!en) begin
                // Any measurement in flight is discarded; period holds.
                state    <= S_IDLE;
                cnt      <= '0;
                locked   <= 1'b0;
                overflow <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: state <= S_ARM;
                    S_ARM: begin
                        if (rise) begin
                            cnt   <= CNT_ONE;
                            state <= S_MEAS;
                        end
                    end
                    S_MEAS: begin
                        if (rise) begin
                            period     <= cnt;
                            meas_valid <= 1'b1;
                            locked     <= 1'b1;
                            cnt        <= CNT_ONE;
                        end else if (cnt == CNT_MAX) begin
                            overflow <= 1'b1;
                            locked   <= 1'b0;
                            cnt      <= '0;
                            state    <= S_ARM;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef PULSE_METER_DUTY_EN
    logic             fall;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] hlat;

    assign fall = ~s & s_d;

    // hcnt counts the synchronized high cycles since the last rise. hlat
    // captures hcnt on the falling edge, so the value is ready when the
    // next rise closes the period.
    always_ff @(posedge clki or negedge rsti_n) begin
        if (!rsti_n) begin
            hcnt      <= '0;
            hlat      <= '0;
            high_time <= '0;
        end else if (!en) begin
            hcnt <= '0;
        end else begin
            case (state)
                S_ARM: begin
                    if (rise) hcnt <= CNT_ONE;
                end
                S_MEAS: begin
                    if (rise) begin
                        high_time <= hlat;
                        hcnt      <= CNT_ONE;
                    end else if (cnt == CNT_MAX) begin
                        hcnt <= '0;
                    end else begin
                        if (s && (hcnt != CNT_MAX)) hcnt <= hcnt + CNT_ONE;
                        if (fall) hlat <= hcnt;
                    end
                end
                default: hcnt <= '0;
            endcase
        end
    end
`else
    assign high_time = '0;
`endif

endmodule

// File: tb/tb_pulse_period_meter.sv
// tb_pulse_period_meter
//   Directed bench for pulse_period_meter, built with CNT_W=8 so that
//   saturation is reachable quickly. Expected high_time follows the build:
//   with PULSE_METER_DUTY_EN the duty value is expected, otherwise zero.
module tb_pulse_period_meter;

    localparam int CNT_W = 8;

    logic             clki;
    logic             rsti_n;
    logic             en;
    logic             sig_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             locked;
    logic             overflow;
    logic [1:0]       state_dbg;

    int total = 0;
    int bad   = 0;
    int strobes = 0;
    int exp_period = 0;
    int exp_high   = 0;
    logic prev_valid = 1'b0;

    pulse_period_meter #(.CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
        .clki       (clki),
        .rsti_n     (rsti_n),
        .en         (en),
        .sig_in     (sig_in),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .locked     (locked),
        .overflow   (overflow),
        .state_dbg  (state_dbg)
    );

    // clock / reset
    initial clki = 1'b0;
    always #5 clki = ~clki;

    function automatic int duty(input int h);
`ifdef PULSE_METER_DUTY_EN
        return h;
`else
        return 0;
`endif
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive sig_in for n cycles; sample #1 after each rising edge and
    // check every strobe against the current expectation.
    task automatic drive(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            sig_in = v;
            @(posedge clki);
            #1;
            if (meas_valid) begin
                strobes++;
                check("valid_gap", int'(prev_valid), 0);
                check("period", int'(period), exp_period);
                check("high_time", int'(high_time), exp_high);
            end
            prev_valid = meas_valid;
        end
    endtask

    task automatic wave(input int h, input int l, input int n);
        for (int p = 0; p < n; p++) begin
            drive(1'b1, h);
            drive(1'b0, l);
        end
    endtask

    initial begin
        // reset state
        rsti_n = 1'b0;
        en     = 1'b0;
        sig_in = 1'b0;
        #3;
        check("rst_period", int'(period), 0);
        check("rst_high", int'(high_time), 0);
        check("rst_valid", int'(meas_valid), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_state", int'(state_dbg), 0);
        repeat (2) @(posedge clki);
        #1;
        rsti_n = 1'b1;
        drive(1'b0, 2);

        // 10 high / 10 low: first rise arms, the next four strobe
        en = 1'b1;
        drive(1'b0, 3);
        strobes = 0;
        exp_period = 20;
        exp_high   = duty(10);
        wave(10, 10, 5);
        check("t1_strobes", strobes, 4);
        check("t1_locked", int'(locked), 1);
        check("t1_overflow", int'(overflow), 0);
        check("t1_period", int'(period), 20);

        // en low: lock drops, period holds
        en = 1'b0;
        drive(1'b0, 3);
        check("idle_locked", int'(locked), 0);
        check("idle_period", int'(period), 20);
        check("idle_state", int'(state_dbg), 0);

        // 1 high / 2 low
        en = 1'b1;
        strobes = 0;
        exp_period = 3;
        exp_high   = duty(1);
        wave(1, 2, 6);
        check("t2_strobes", strobes, 5);
        check("t2_locked", int'(locked), 1);

        // held low: last rise processed two edges into the final period;
        // saturation lands exactly 255 edges later
        drive(1'b0, 254);
        check("sat_pre_overflow", int'(overflow), 0);
        check("sat_pre_locked", int'(locked), 1);
        drive(1'b0, 1);
        check("sat_overflow", int'(overflow), 1);
        check("sat_locked", int'(locked), 0);
        check("sat_state", int'(state_dbg), 1);
        check("sat_strobes", strobes, 5);

        // resumed pulses relock, overflow stays sticky
        strobes = 0;
        exp_period = 20;
        exp_high   = duty(10);
        wave(10, 10, 3);
        check("relock_strobes", strobes, 2);
        check("relock_locked", int'(locked), 1);
        check("relock_overflow", int'(overflow), 1);
        en = 1'b0;
        drive(1'b0, 2);
        check("ovf_clear", int'(overflow), 0);

        // en dropped mid-period
        en = 1'b1;
        strobes = 0;
        wave(10, 10, 2);
        drive(1'b1, 10);
        check("t4_strobes", strobes, 2);
        drive(1'b0, 5);
        en = 1'b0;
        drive(1'b0, 3);
        check("t4_locked", int'(locked), 0);
        check("t4_no_strobe", strobes, 2);
        check("t4_period_hold", int'(period), 20);
        en = 1'b1;
        strobes = 0;
        drive(1'b0, 3);
        drive(1'b1, 10);
        drive(1'b0, 10);
        check("t4_first_rise", strobes, 0);
        drive(1'b1, 10);
        check("t4_second_rise", strobes, 1);
        check("t4_relocked", int'(locked), 1);

        // async reset mid-period
        drive(1'b0, 5);
        rsti_n = 1'b0;
        #1;
        check("ar_period", int'(period), 0);
        check("ar_high", int'(high_time), 0);
        check("ar_valid", int'(meas_valid), 0);
        check("ar_locked", int'(locked), 0);
        check("ar_overflow", int'(overflow), 0);
        #1;
        rsti_n = 1'b1;
        drive(1'b0, 3);
        strobes = 0;
        drive(1'b1, 10);
        drive(1'b0, 10);
        check("ar_first_rise", strobes, 0);
        check("ar_first_locked", int'(locked), 0);
        drive(1'b1, 10);
        check("ar_second_rise", strobes, 1);
        check("ar_locked_again", int'(locked), 1);

        // rise coinciding with saturation: period = 255, no overflow
        drive(1'b0, 10);
        strobes = 0;
        drive(1'b1, 10);
        exp_period = 255;
        drive(1'b0, 245);
        drive(1'b1, 10);
        check("max_strobes", strobes, 2);
        check("max_period", int'(period), 255);
        check("max_overflow", int'(overflow), 0);
        check("max_locked", int'(locked), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
